// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// state codes, opcodes, ALU op codes and datapath select codes.
package mc_ctrl_pkg;

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath: Moore decode of
// state, with FETCH write enables and FETCH/memory advance qualified by mem_ready.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit          ADDI_EN = 1'b1,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state_out,
  output logic               illegal_op
);

  logic [3:0] state;
  logic [3:0] state_nx;
  ctrl_t      c;
  ctrl_t      cw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_nx;
  end

  always_comb begin
    c        = '0;
    state_nx = S_RESET;
    case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        state_nx    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_nx = S_MEM_ADDR;
          OP_RTYPE:     state_nx = S_R_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI:      state_nx = ADDI_EN ? S_ADDI_EXEC : S_TRAP;
          default:      state_nx = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        state_nx    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        state_nx   = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_nx     = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        state_nx    = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
        state_nx    = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_nx    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        state_nx    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
        state_nx    = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        state_nx        = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        state_nx    = S_FETCH;
      end
      S_TRAP: begin
        c.illegal_op = 1'b1;
        state_nx     = S_FETCH;
      end
      default: state_nx = S_RESET;
    endcase
  end

  // Gate on rst as well so nothing is enabled while reset is asserted,
  // independent of when the asynchronous clear lands.
  always_comb begin
    cw = rst ? '0 : c;
  end

  assign pc_write      = cw.pc_write;
  assign pc_write_cond = cw.pc_write_cond;
  assign pc_en         = cw.pc_write | (cw.pc_write_cond & zero);
  assign i_or_d        = cw.i_or_d;
  assign mem_read      = cw.mem_read;
  assign mem_write     = cw.mem_write;
  assign ir_write      = cw.ir_write;
  assign mem_to_reg    = cw.mem_to_reg;
  assign reg_dst       = cw.reg_dst;
  assign reg_write     = cw.reg_write;
  assign alu_src_a     = cw.alu_src_a;
  assign alu_src_b     = cw.alu_src_b;
  assign alu_op        = cw.alu_op;
  assign pc_source     = cw.pc_source;
  assign illegal_op    = cw.illegal_op;
  assign state_out     = STATE_W'(state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: instruction-level reference model pushes
// per-cycle expected control words; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3,
                 ST_MEM_READ = 4, ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_R_EXEC = 7,
                 ST_R_WB = 8, ST_ADDI_EXEC = 9, ST_ADDI_WB = 10, ST_BRANCH = 11,
                 ST_JUMP = 12, ST_TRAP = 13;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_out;

  // Second instance with addi disabled, free-running on a fixed addi opcode.
  logic       rst_b = 1'b1;
  logic [5:0] opcode_b = 6'b001000;
  logic       zero_b = 1'b0;
  logic       mem_ready_b = 1'b1;
  logic       pc_en_b, pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b;
  logic       ir_write_b, mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, illegal_op_b;
  logic [1:0] alu_src_b_b, alu_op_b, pc_source_b;
  logic [3:0] state_out_b;

  int   errs = 0;
  int   checks = 0;
  exp_t q[$];
  logic [5:0] cur_op = '0;
  int   force_zero = 2;
  bit   bchk_done = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.ADDI_EN(1'b1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state_out(state_out),
    .illegal_op(illegal_op)
  );

  mc_control_fsm #(.ADDI_EN(1'b0), .STATE_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b), .zero(zero_b), .mem_ready(mem_ready_b),
    .pc_en(pc_en_b), .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
    .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .ir_write(ir_write_b), .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b),
    .reg_write(reg_write_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_op(alu_op_b), .pc_source(pc_source_b), .state_out(state_out_b),
    .illegal_op(illegal_op_b)
  );

  function automatic exp_t sample();
    exp_t a;
    a = {state_out, pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
         pc_source, illegal_op};
    return a;
  endfunction

  // Expected control word for one cycle of a given step, from the state table.
  function automatic exp_t model(int st, logic mr, logic z);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      ST_FETCH: begin
        e.mem_read = 1; e.alu_src_b = 2'b01;
        e.ir_write = mr; e.pc_write = mr; e.pc_en = mr;
      end
      ST_DECODE:    e.alu_src_b = 2'b11;
      ST_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_MEM_READ:  begin e.mem_read = 1; e.i_or_d = 1; end
      ST_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
      ST_MEM_WRITE: begin e.mem_write = 1; e.i_or_d = 1; end
      ST_R_EXEC:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      ST_R_WB:      begin e.reg_write = 1; e.reg_dst = 1; end
      ST_ADDI_EXEC: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_ADDI_WB:   e.reg_write = 1;
      ST_BRANCH: begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
        e.pc_source = 2'b01; e.pc_en = z;
      end
      ST_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; e.pc_en = 1; end
      ST_TRAP:      e.illegal_op = 1;
      default:      ;
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input int st, input logic mr);
    mem_ready = mr;
    zero = (force_zero == 2) ? 1'($urandom) : (force_zero == 1);
    opcode = (st == ST_FETCH) ? 6'($urandom) : cur_op;
    q.push_back(model(st, mr, zero));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    cur_op = op;
    repeat (fs) cyc(ST_FETCH, 1'b0);
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, rb());
    case (op)
      6'b100011: begin
        cyc(ST_MEM_ADDR, rb());
        repeat (ms) cyc(ST_MEM_READ, 1'b0);
        cyc(ST_MEM_READ, 1'b1);
        cyc(ST_MEM_WB, rb());
      end
      6'b101011: begin
        cyc(ST_MEM_ADDR, rb());
        repeat (ms) cyc(ST_MEM_WRITE, 1'b0);
        cyc(ST_MEM_WRITE, 1'b1);
      end
      6'b000000: begin cyc(ST_R_EXEC, rb()); cyc(ST_R_WB, rb()); end
      6'b001000: begin cyc(ST_ADDI_EXEC, rb()); cyc(ST_ADDI_WB, rb()); end
      6'b000100: cyc(ST_BRANCH, rb());
      6'b000010: cyc(ST_JUMP, rb());
      default:   cyc(ST_TRAP, rb());
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errs++;
        $display("FAIL ctrl: got state=%0d word=%h, expected state=%0d word=%h",
                 a.st, a[17:0], e.st, e[17:0]);
      end
    end
  end

  // addi with ADDI_EN=0 must cycle FETCH -> DECODE -> TRAP and never write.
  initial begin
    int exp_st;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp_st = (k == 0) ? ST_RESET : ((k - 1) % 3 == 0) ? ST_FETCH :
               ((k - 1) % 3 == 1) ? ST_DECODE : ST_TRAP;
      checks++;
      if (state_out_b !== 4'(exp_st) || illegal_op_b !== (exp_st == ST_TRAP) ||
          reg_write_b !== 1'b0 || mem_write_b !== 1'b0) begin
        errs++;
        $display("FAIL addi_dis k=%0d: got state=%0d illegal=%b rw=%b mw=%b, expected state=%0d illegal=%b rw=0 mw=0",
                 k, state_out_b, illegal_op_b, reg_write_b, mem_write_b, exp_st, exp_st == ST_TRAP);
      end
    end
    bchk_done = 1;
  end

  initial begin
    logic [5:0] legal [6];
    logic [5:0] op;
    bit         ok;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    @(posedge clk);
    #1;
    cyc(ST_RESET, 1'b1);
    cyc(ST_RESET, 1'b1);
    rst = 1'b0;
    cyc(ST_RESET, 1'b1);

    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 3, 0);
    force_zero = 1; run_instr(6'b000100, 0, 0);
    force_zero = 0; run_instr(6'b000100, 0, 0);
    force_zero = 2;
    run_instr(6'b101011, 0, 2);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b000010, 0, 0);

    // Async reset while lw is stalled in MEM_READ.
    cur_op = 6'b100011;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, 1'b1);
    cyc(ST_MEM_ADDR, 1'b1);
    mem_ready = 1'b0;
    q.push_back(model(ST_MEM_READ, 1'b0, zero));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sample() !== {4'(ST_RESET), 18'h0}) begin
      errs++;
      $display("FAIL async_rst: got %h, expected %h", sample(), {4'(ST_RESET), 18'h0});
    end
    @(posedge clk);
    #1;
    cyc(ST_RESET, 1'b1);
    rst = 1'b0;
    cyc(ST_RESET, 1'b1);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          do begin
            op = 6'($urandom);
            ok = 1;
            foreach (legal[i]) if (op == legal[i]) ok = 0;
          end while (!ok);
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0 || !bchk_done) begin
      errs++;
      $display("FAIL drain: got pending=%0d done=%0d, expected pending=0 done=1", q.size(), bchk_done);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
